// File: rtl/mc_control_unit_pkg.sv
// Shared types for the multicycle control unit: FSM states,
// instruction class codes and datapath mux / ALU encodings.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADDR = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      REXEC   = 4'd6,
      RWB     = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9,
      IEXEC   = 4'd10,
      IWB     = 4'd11,
      FAULT   = 4'd12
   } state_e;

   localparam logic [2:0] CLS_R   = 3'b000;
   localparam logic [2:0] CLS_I   = 3'b100;
   localparam logic [2:0] CLS_BR  = 3'b010;
   localparam logic [2:0] CLS_MEM = 3'b001;
   localparam logic [2:0] CLS_J   = 3'b111;

   localparam logic [1:0] PC_ALU = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   localparam logic [1:0] DS_MDR = 2'b00;
   localparam logic [1:0] DS_ALU = 2'b01;
   localparam logic [1:0] DS_PC  = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // States that wait on the mem_ready handshake.
   function automatic logic is_mem_wait(state_e s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bundle between the control unit and the datapath.
// master: control unit (drives controls); slave: datapath side.
interface mc_control_unit_if #(
   parameter int OPCODE_W = 6
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                pc_cond;
   logic                pc_write;
   logic [1:0]          pc_src;
   logic                mem_src;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                reg_src;
   logic                reg_write;
   logic [1:0]          data_src;
   logic                link_dst;
   logic                a_src;
   logic [1:0]          b_src;
   logic [1:0]          alu_op;
   logic                branch_ne;
   logic                instr_done;
   logic                fault;
   logic [3:0]          state;

   modport master (
      input  opcode, mem_ready,
      output pc_cond, pc_write, pc_src, mem_src, mem_read,
      output mem_write, ir_write, reg_src, reg_write, data_src,
      output link_dst, a_src, b_src, alu_op, branch_ne,
      output instr_done, fault, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_cond, pc_write, pc_src, mem_src, mem_read,
      input  mem_write, ir_write, reg_src, reg_write, data_src,
      input  link_dst, a_src, b_src, alu_op, branch_ne,
      input  instr_done, fault, state
   );
endinterface

// File: rtl/mc_control_unit_timer.sv
// Memory wait counter. Counts cycles spent waiting on mem_ready;
// ports: clk, reset, clear, waiting (wait cycle), expired.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic waiting,
   output logic expired
);
   localparam int W =
      (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

   logic [W-1:0] cnt;

   // Holds at LIMIT once reached; a zero limit never expires.
   assign expired = (MEM_TIMEOUT > 0) && (cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (waiting && !expired)
         cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM with mem_ready stalls and timeout fault.
// Ports: clk, reset (sync, active-high), bus (control bundle).
module mc_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,
   mc_control_unit_if.master bus
);
   state_e     state_q;
   state_e     state_d;
   logic [2:0] cls;
   logic       sub;
   logic       rdy;
   logic       expired;
   logic       waiting;
   logic       unused_op;

   assign cls       = bus.opcode[OPCODE_W-1 -: 3];
   assign sub       = bus.opcode[0];
   assign rdy       = bus.mem_ready;
   assign unused_op = ^bus.opcode;
   assign waiting   = is_mem_wait(state_q) && !rdy;

   // Any state change clears the counter, which covers
   // every entry into a memory-wait state.
   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_d != state_q),
      .waiting (waiting),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH:
            if (rdy)          state_d = DECODE;
            else if (expired) state_d = FAULT;
         DECODE:
            unique case (1'b1)
               (cls == CLS_R):   state_d = REXEC;
               (cls == CLS_I):   state_d = IEXEC;
               (cls == CLS_BR):  state_d = BRANCH;
               (cls == CLS_MEM): state_d = MEMADDR;
               (cls == CLS_J):   state_d = JUMP;
               default:          state_d = FAULT;
            endcase
         MEMADDR: state_d = sub ? MEMWR : MEMRD;
         MEMRD:
            if (rdy)          state_d = MEMWB;
            else if (expired) state_d = FAULT;
         MEMWR:
            if (rdy)          state_d = FETCH;
            else if (expired) state_d = FAULT;
         REXEC:   state_d = RWB;
         IEXEC:   state_d = IWB;
         MEMWB,
         RWB,
         IWB,
         BRANCH,
         JUMP:    state_d = FETCH;
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   assign bus.state = state_q;
   assign bus.fault = (state_q == FAULT);

   always_comb begin
      bus.pc_cond    = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = PC_ALU;
      bus.mem_src    = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_src    = 1'b0;
      bus.reg_write  = 1'b0;
      bus.data_src   = DS_MDR;
      bus.link_dst   = 1'b0;
      bus.a_src      = 1'b0;
      bus.b_src      = 2'b00;
      bus.alu_op     = ALU_ADD;
      bus.branch_ne  = 1'b0;
      bus.instr_done = 1'b0;
      unique case (state_q)
         FETCH: begin
            bus.mem_read = 1'b1;
            bus.b_src    = 2'b01;
            bus.ir_write = rdy;
            bus.pc_write = rdy;
         end
         DECODE: bus.b_src = 2'b11;
         MEMADDR: begin
            bus.a_src = 1'b1;
            bus.b_src = 2'b10;
         end
         MEMRD: begin
            bus.mem_read = 1'b1;
            bus.mem_src  = 1'b1;
         end
         MEMWR: begin
            bus.mem_write  = 1'b1;
            bus.mem_src    = 1'b1;
            bus.instr_done = rdy;
         end
         MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.data_src   = DS_MDR;
            bus.instr_done = 1'b1;
         end
         REXEC: begin
            bus.a_src  = 1'b1;
            bus.alu_op = ALU_FUNCT;
         end
         RWB: begin
            bus.reg_write  = 1'b1;
            bus.reg_src    = 1'b1;
            bus.data_src   = DS_ALU;
            bus.instr_done = 1'b1;
         end
         IEXEC: begin
            bus.a_src  = 1'b1;
            bus.b_src  = 2'b10;
            bus.alu_op = ALU_FUNCT;
         end
         IWB: begin
            bus.reg_write  = 1'b1;
            bus.data_src   = DS_ALU;
            bus.instr_done = 1'b1;
         end
         BRANCH: begin
            bus.a_src      = 1'b1;
            bus.alu_op     = ALU_SUB;
            bus.pc_cond    = 1'b1;
            bus.pc_src     = PC_BR;
            bus.branch_ne  = sub;
            bus.instr_done = 1'b1;
         end
         JUMP: begin
            bus.pc_write   = 1'b1;
            bus.pc_src     = PC_JMP;
            bus.instr_done = 1'b1;
            if (sub) begin
               bus.reg_write = 1'b1;
               bus.data_src  = DS_PC;
               bus.link_dst  = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: random instruction
// streams, expected per-cycle states/controls queued and checked.
module tb_mc_control_unit;
   import cpu_ctrl_pkg::*;

   localparam int OW = 6;
   localparam int T  = 4;

   typedef struct packed {
      logic       pc_cond;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       mem_src;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_src;
      logic       reg_write;
      logic [1:0] data_src;
      logic       link_dst;
      logic       a_src;
      logic [1:0] b_src;
      logic [1:0] alu_op;
      logic       branch_ne;
      logic       instr_done;
      logic       fault;
   } ctrl_t;

   typedef struct packed {
      state_e s;
      ctrl_t  c;
   } exp_t;

   typedef struct {
      state_e s;
      bit     rdy;
   } ph_t;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   tie1 = 1'b0;
   exp_t sb[$];
   ph_t  ph[$];
   exp_t e;
   ctrl_t act;

   always #5 clk = ~clk;

   mc_control_unit_if #(.OPCODE_W(OW)) bus ();

   mc_control_unit #(
      .OPCODE_W    (OW),
      .MEM_TIMEOUT (T)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Control word each state must present, straight from the
   // output table; rdy only matters where outputs follow it.
   function automatic ctrl_t spec_ctrl(state_e s, bit sub, bit rdy);
      ctrl_t c = '0;
      case (s)
         FETCH: begin
            c.mem_read = 1; c.b_src = 2'b01;
            c.ir_write = rdy; c.pc_write = rdy;
         end
         DECODE:  c.b_src = 2'b11;
         MEMADDR: begin c.a_src = 1; c.b_src = 2'b10; end
         MEMRD:   begin c.mem_read = 1; c.mem_src = 1; end
         MEMWR: begin
            c.mem_write = 1; c.mem_src = 1; c.instr_done = rdy;
         end
         MEMWB: begin c.reg_write = 1; c.instr_done = 1; end
         REXEC: begin c.a_src = 1; c.alu_op = 2'b10; end
         RWB: begin
            c.reg_write = 1; c.reg_src = 1;
            c.data_src = 2'b01; c.instr_done = 1;
         end
         IEXEC: begin
            c.a_src = 1; c.b_src = 2'b10; c.alu_op = 2'b10;
         end
         IWB: begin
            c.reg_write = 1; c.data_src = 2'b01; c.instr_done = 1;
         end
         BRANCH: begin
            c.a_src = 1; c.alu_op = 2'b01; c.pc_cond = 1;
            c.pc_src = 2'b01; c.branch_ne = sub; c.instr_done = 1;
         end
         JUMP: begin
            c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1;
            if (sub) begin
               c.reg_write = 1; c.data_src = 2'b10; c.link_dst = 1;
            end
         end
         FAULT: c.fault = 1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic bit noise();
      return tie1 ? 1'b1 : 1'($urandom);
   endfunction

   // w stall cycles then the ready cycle; more than T stalls
   // means T+1 low cycles and then a fault.
   task automatic add_wait(state_e s, int w, output bit ok);
      if (w <= T) begin
         repeat (w) ph.push_back('{s, 1'b0});
         ph.push_back('{s, 1'b1});
         ok = 1'b1;
      end else begin
         repeat (T + 1) ph.push_back('{s, 1'b0});
         ok = 1'b0;
      end
   endtask

   task automatic run_instr(logic [2:0] cls, bit sub,
                            int wf, int wd, int rst_at);
      bit ok;
      logic [OW-1:0] op;
      op = {cls, 2'($urandom), sub};
      ph.delete();
      add_wait(FETCH, wf, ok);
      if (ok) begin
         ph.push_back('{DECODE, noise()});
         case (cls)
            CLS_R: begin
               ph.push_back('{REXEC, noise()});
               ph.push_back('{RWB, noise()});
            end
            CLS_I: begin
               ph.push_back('{IEXEC, noise()});
               ph.push_back('{IWB, noise()});
            end
            CLS_BR: ph.push_back('{BRANCH, noise()});
            CLS_J:  ph.push_back('{JUMP, noise()});
            CLS_MEM: begin
               ph.push_back('{MEMADDR, noise()});
               if (!sub) begin
                  add_wait(MEMRD, wd, ok);
                  if (ok) ph.push_back('{MEMWB, noise()});
               end else begin
                  add_wait(MEMWR, wd, ok);
               end
            end
            default: ok = 1'b0;
         endcase
      end
      if (!ok) begin
         repeat (3) ph.push_back('{FAULT, 1'($urandom)});
         if (rst_at < 0 || rst_at >= ph.size())
            rst_at = ph.size() - 1;
      end
      for (int i = 0; i < ph.size(); i++) begin
         @(negedge clk);
         reset = (i == rst_at);
         bus.opcode = (ph[i].s == FETCH) ? OW'($urandom) : op;
         bus.mem_ready = ph[i].rdy;
         sb.push_back('{ph[i].s, spec_ctrl(ph[i].s, sub, ph[i].rdy)});
         if (i == rst_at) break;
      end
   endtask

   task automatic reset_cycle();
      bit r;
      @(negedge clk);
      r = 1'($urandom);
      reset = 1'b1;
      bus.mem_ready = r;
      sb.push_back('{FETCH, spec_ctrl(FETCH, 1'b0, r)});
   endtask

   always begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         act.pc_cond    = bus.pc_cond;
         act.pc_write   = bus.pc_write;
         act.pc_src     = bus.pc_src;
         act.mem_src    = bus.mem_src;
         act.mem_read   = bus.mem_read;
         act.mem_write  = bus.mem_write;
         act.ir_write   = bus.ir_write;
         act.reg_src    = bus.reg_src;
         act.reg_write  = bus.reg_write;
         act.data_src   = bus.data_src;
         act.link_dst   = bus.link_dst;
         act.a_src      = bus.a_src;
         act.b_src      = bus.b_src;
         act.alu_op     = bus.alu_op;
         act.branch_ne  = bus.branch_ne;
         act.instr_done = bus.instr_done;
         act.fault      = bus.fault;
         n_chk++;
         if (bus.state !== e.s) begin
            n_fail++;
            $display("FAIL state t=%0t got %0d want %0d (%s)",
                     $time, bus.state, e.s, e.s.name());
         end
         n_chk++;
         if (act !== e.c) begin
            n_fail++;
            $display("FAIL ctrl[%s] t=%0t got %h want %h",
                     e.s.name(), $time, act, e.c);
         end
      end
   end

   initial begin
      logic [2:0] cl;
      logic [2:0] classes [8];
      classes = '{CLS_R, CLS_I, CLS_BR, CLS_MEM,
                  CLS_J, 3'b011, 3'b101, 3'b110};
      reset = 1'b1;
      bus.opcode = '0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      reset_cycle();
      reset_cycle();

      tie1 = 1'b1;
      run_instr(CLS_R, 1'b0, 0, 0, -1);
      tie1 = 1'b0;
      run_instr(CLS_MEM, 1'b0, 0, 3, -1);
      run_instr(CLS_BR, 1'b1, 0, 0, -1);
      run_instr(CLS_J, 1'b1, 0, 0, -1);
      run_instr(CLS_I, 1'b0, 2, 0, -1);
      run_instr(CLS_MEM, 1'b1, T, T, -1);
      run_instr(CLS_R, 1'b0, T + 1, 0, -1);
      run_instr(3'b110, 1'b0, 0, 0, -1);
      run_instr(CLS_MEM, 1'b1, 0, 3, 4);
      run_instr(CLS_MEM, 1'b0, 0, T + 1, -1);
      run_instr(CLS_MEM, 1'b1, 1, T + 1, -1);
      run_instr(CLS_J, 1'b0, T, 0, -1);

      for (int k = 0; k < 40; k++) begin
         cl = classes[$urandom_range(0, 7)];
         run_instr(cl, 1'($urandom),
                   $urandom_range(0, T + 1),
                   $urandom_range(0, T + 1),
                   ($urandom_range(0, 7) == 0) ?
                      $urandom_range(0, 6) : -1);
      end

      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d left want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
